// File: rtl/serdes_frame_tx_ctrl.sv
// Frame sequencer ahead of serdes_tx: wraps upstream payload bytes as SOF, payload, EOF,
// paced by the PISO load strobe, then holds off for an inter-frame gap.
module serdes_frame_tx_ctrl #(
   parameter int MAX_LEN    = 16,
   parameter int IFG_CYCLES = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   input  logic       s_last,
   output logic       s_ready,
   input  logic       tx_load,
   output logic [8:0] tx_data,
   output logic       tx_enable,
   output logic       busy,
   output logic       frame_done,
   output logic       frame_trunc,
   output logic [7:0] underrun_cnt
);

   localparam int CW = $clog2(MAX_LEN + 1);
   localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_LEN);
   localparam logic [GW-1:0] GAP_INIT = GW'(IFG_CYCLES - 1);

   localparam logic [8:0] SOF_W  = 9'h13C;
   localparam logic [8:0] EOF_W  = 9'h1BC;
   localparam logic [8:0] FILL_W = 9'h11C;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_SOF,
      S_PAYLOAD,
      S_EOF,
      S_DROP,
      S_GAP
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          last_flag;
   logic          drop_pending;
   logic [GW-1:0] gap;
   logic          room;

   // Payload may still grow: no terminating byte seen and length cap not reached.
   assign room = !last_flag && (count < MAX_CNT);

   always_comb begin
      s_ready = (tx_load && ((state == S_SOF) || (state == S_PAYLOAD && room)))
                || (state == S_DROP);
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         tx_data      <= '0;
         tx_enable    <= 1'b0;
         count        <= '0;
         last_flag    <= 1'b0;
         drop_pending <= 1'b0;
         gap          <= '0;
         underrun_cnt <= '0;
         frame_done   <= 1'b0;
         frame_trunc  <= 1'b0;
      end else begin
         frame_done  <= 1'b0;
         frame_trunc <= 1'b0;
         case (state)
            S_IDLE: begin
               if (s_valid) begin
                  tx_data      <= SOF_W;
                  count        <= '0;
                  last_flag    <= 1'b0;
                  drop_pending <= 1'b0;
                  state        <= S_ARM;
               end
            end
            // Enable trails the SOF word by one clock so the PISO never sees stale data.
            S_ARM: begin
               tx_enable <= 1'b1;
               state     <= S_SOF;
            end
            S_SOF: begin
               if (tx_load) begin
                  state <= S_PAYLOAD;
                  if (s_valid) begin
                     tx_data   <= {1'b0, s_data};
                     last_flag <= s_last;
                     count     <= CW'(1);
                  end else begin
                     tx_data <= FILL_W;
                     count   <= '0;
                     if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
                  end
               end
            end
            S_PAYLOAD: begin
               if (tx_load) begin
                  if (last_flag) begin
                     tx_data <= EOF_W;
                     state   <= S_EOF;
                  end else if (count == MAX_CNT) begin
                     tx_data      <= EOF_W;
                     frame_trunc  <= 1'b1;
                     drop_pending <= 1'b1;
                     state        <= S_EOF;
                  end else if (s_valid) begin
                     tx_data   <= {1'b0, s_data};
                     count     <= count + CW'(1);
                     last_flag <= s_last;
                  end else begin
                     tx_data <= FILL_W;
                     if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
                  end
               end
            end
            S_EOF: begin
               if (tx_load) begin
                  frame_done <= 1'b1;
                  tx_enable  <= 1'b0;
                  gap        <= GAP_INIT;
                  last_flag  <= 1'b0;
                  state      <= drop_pending ? S_DROP : S_GAP;
               end
            end
            // Residue of a truncated frame is swallowed while the gap timer keeps running.
            S_DROP: begin
               if (gap != '0) gap <= gap - GW'(1);
               if (s_valid && s_last) begin
                  drop_pending <= 1'b0;
                  state        <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap == '0) state <= S_IDLE;
               else           gap   <= gap - GW'(1);
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/serdes_frame_tx_ctrl.md
Name: serdes_frame_tx_ctrl

Overview:
Frame sequencer in front of serdes_tx (8b/10b encoder + PISO). It takes payload bytes from an upstream valid/ready stream and drives serdes_tx data_in/enable. Each frame is sent as K28.1 (SOF), payload, then K28.5 (EOF), followed by an inter-frame gap. Word advance is paced by the serializer's load strobe (load_piso, one pulse per 10-bit slot).

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (≥1); count width = clog2(MAX_LEN+1)
IFG_CYCLES, 20, idle clk cycles after EOF load before next SOF may arm (≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
s_valid  input  1  upstream payload byte valid
s_data  input  8  upstream payload byte
s_last  input  1  marks final byte of frame
s_ready  output  1  combinational; byte accepted when s_valid&&s_ready at posedge
tx_load  input  1  serdes_tx load_piso pulse; PISO samples tx_data on this edge
tx_data  output  9  {K,byte} to serdes_tx data_in (registered)
tx_enable  output  1  serdes_tx enable (registered)
busy  output  1  high in any state except IDLE
frame_done  output  1  1-cycle pulse on EOF-load edge
frame_trunc  output  1  1-cycle pulse when EOF forced by MAX_LEN
underrun_cnt  output  8  saturating count of fill words inserted

Behaviour:
- Codes: SOF=9'h13C (K28.1), EOF=9'h1BC (K28.5), FILL=9'h11C (K28.0), data={1'b0,s_data}.
- Reset (sync, any state): state=IDLE, tx_data=0, tx_enable=0, count=0, last_flag=0, underrun_cnt=0, frame_done=0, frame_trunc=0, GAP counter=0. Mid-frame reset abandons the frame without emitting EOF.
- PISO samples tx_data at the tx_load edge. The controller updates tx_data at that same edge, so the new word is the one presented for the next slot.
- IDLE: tx_enable=0. When s_valid=1: tx_data<=SOF, go to ARM. The byte is not consumed.
- ARM: exactly one cycle. tx_enable<=1 (enable follows data by one clk). Go to SOF.
- SOF: wait for tx_load. On tx_load:
  - if s_valid: accept the byte, tx_data<=data, last_flag<=s_last, count<=1, go to PAYLOAD;
  - else: tx_data<=FILL, underrun_cnt++ (saturate at 255), go to PAYLOAD with count=0.
- PAYLOAD: on tx_load:
  - if last_flag: tx_data<=EOF, go to EOF.
  - elif count==MAX_LEN: tx_data<=EOF, pulse frame_trunc, go to EOF, set drop_pending.
  - elif s_valid: accept the byte, tx_data<=data, count++, last_flag<=s_last.
  - else: tx_data<=FILL, underrun_cnt++.
  - FILL words do not increment count.
- s_ready = tx_load && ((state==SOF) || (state==PAYLOAD && !last_flag && count<MAX_LEN)) || (state==DROP).
- EOF: on tx_load (the EOF word is captured): pulse frame_done, tx_enable<=0, GAP counter<=IFG_CYCLES-1. Go to DROP if drop_pending, else GAP.
- DROP: s_ready=1; discard bytes until an accepted byte has s_last=1, then go to GAP. The GAP counter runs in parallel.
- GAP: decrement each cycle; at 0, go to IDLE. tx_data keeps EOF and is ignored since enable=0.
- Simultaneous events:
  - s_valid rising in GAP is ignored until IDLE.
  - tx_load in IDLE/ARM/GAP is ignored.
  - A 1-byte frame (s_last on the first byte) yields SOF, D, EOF.

Test Plan:
- Frame 0xAA,0x55(last) with s_valid held: serdes_tx loads 13C, 0AA, 055, 1BC in order. tx_enable rises one clk after tx_data=13C. frame_done pulses once. underrun_cnt=0.
- Single byte 0x3C with s_last=1: load sequence 13C, 03C, 1BC. s_ready high exactly once.
- Upstream stalls 2 slots between 0x11 and 0x22(last): loads 13C, 011, 11C, 11C, 022, 1BC. underrun_cnt=2.
- MAX_LEN=4 with an 6-byte frame: loads 13C, 4 data, 1BC. frame_trunc pulses. Bytes 5-6 are drained in DROP and not sent.
- Back-to-back frames: second SOF load occurs no earlier than IFG_CYCLES+2 clk after first frame_done. tx_enable is 0 throughout the gap.
- Reset asserted in PAYLOAD: next clk tx_enable=0, tx_data=0, busy=0. A new frame afterwards starts with SOF.
